// File: rtl/texture_ram_pkg.sv
// Shared constants and FSM encoding for the texture RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package texture_ram_pkg;

  localparam int TEX_DEPTH = 107120;
  localparam int TEX_AW    = 17;
  localparam int TEX_DW    = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a grant enable.
// Latency: combinational grant; priority pointer updates on the next clk edge.
// Backpressure: en=0 blocks the grant and freezes the pointer; cand still shows who would win.
//
// Ports:
//   clk, rst  clock and async active-high reset
//   req       request per requester
//   en        allow the candidate to be granted this cycle
//   cand      one-hot winner ignoring en
//   gnt       one-hot grant (cand gated by en)
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] cand,
  output logic [1:0] gnt
);

  // ptr_q = index of the requester that wins when both request
  logic ptr_q;
  logic ptr_d;

  always_comb begin
    cand = 2'b00;
    case (req)
      2'b01:   cand = 2'b01;
      2'b10:   cand = 2'b10;
      2'b11:   cand = ptr_q ? 2'b10 : 2'b01;
      default: cand = 2'b00;
    endcase
    gnt = en ? cand : 2'b00;
  end

  // Priority only moves when a contested grant actually happened; the loser
  // of that contest becomes the favourite.
  always_comb begin
    ptr_d = ptr_q;
    if ((req == 2'b11) && (gnt != 2'b00)) begin
      ptr_d = gnt[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/texture_ram_arbiter.sv
// Arbitrates two writers and two readers onto a single-port-pair texture RAM, with a bulk clear engine.
// Latency: grants combinational; rd_valid/rd_data and addr_err one cycle after the grant.
// Backpressure: requesters hold req until their gnt bit is seen; no grants while clearing.
//
// Ports:
//   clk, rst                               clock, async active-high reset
//   wr_req, wr_addr0/1, wr_data0/1, wr_gnt  write requesters (0 loader, 1 rasterizer)
//   rd_req, rd_addr0/1, rd_gnt              read requesters (0 sampler, 1 output ctrl)
//   rd_valid, rd_data                       read return, one cycle after grant
//   ram_we, ram_write_address, ram_data     RAM write port
//   ram_read_address, ram_q                 RAM read port (1-cycle read latency)
//   clear_start, busy, clear_done           bulk clear control/status
//   addr_err                                pulse for an out-of-range granted access
module texture_ram_arbiter #(
  parameter int TEX_DEPTH = 107120,
  parameter int TEX_AW    = 17,
  parameter int TEX_DW    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        wr_req,
  input  logic [TEX_AW-1:0] wr_addr0,
  input  logic [TEX_AW-1:0] wr_addr1,
  input  logic [TEX_DW-1:0] wr_data0,
  input  logic [TEX_DW-1:0] wr_data1,
  output logic [1:0]        wr_gnt,
  input  logic [1:0]        rd_req,
  input  logic [TEX_AW-1:0] rd_addr0,
  input  logic [TEX_AW-1:0] rd_addr1,
  output logic [1:0]        rd_gnt,
  output logic [1:0]        rd_valid,
  output logic [TEX_DW-1:0] rd_data,
  output logic              ram_we,
  output logic [TEX_AW-1:0] ram_write_address,
  output logic [TEX_DW-1:0] ram_data,
  output logic [TEX_AW-1:0] ram_read_address,
  input  logic [TEX_DW-1:0] ram_q,
  input  logic              clear_start,
  output logic              busy,
  output logic              clear_done,
  output logic              addr_err
);

  import texture_ram_pkg::*;

  localparam logic [TEX_AW-1:0] LAST_ADDR = TEX_AW'(TEX_DEPTH - 1);
  // One extra bit so a depth equal to 2**TEX_AW still compares correctly.
  localparam logic [TEX_AW:0]   DEPTH_W   = (TEX_AW + 1)'(TEX_DEPTH);

  clr_state_e        state_q, state_d;
  logic [TEX_AW-1:0] cnt_q, cnt_d;
  logic [1:0]        rd_valid_q, rd_valid_d;
  logic              rd_oor_q, rd_oor_d;
  logic              addr_err_q, addr_err_d;

  logic              arb_en;
  logic              clr_we;
  logic              rd_en;
  logic              hazard;
  logic [1:0]        wr_cand;
  logic [1:0]        rd_cand;
  logic [TEX_AW-1:0] wa;
  logic [TEX_AW-1:0] ra;
  logic [TEX_DW-1:0] wd;
  logic              w_oor;
  logic              r_oor;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rd_valid_q <= 2'b00;
      rd_oor_q   <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_oor_q   <= rd_oor_d;
      addr_err_q <= addr_err_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TEX_AW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Grants are also masked while rst is high so the RAM sees no write during reset.
  always_comb begin
    busy       = (state_q == ST_CLEAR);
    clear_done = (state_q == ST_DONE);
    clr_we     = (state_q == ST_CLEAR);
    arb_en     = (state_q == ST_IDLE) && !rst;
  end

  // ---------------- arbitration ----------------
  rr_arb2 u_wr_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (wr_req),
    .en   (arb_en),
    .cand (wr_cand),
    .gnt  (wr_gnt)
  );

  // The read candidate is known before its grant so it can be checked against
  // the winning write; a colliding read is held off one cycle with its pointer frozen.
  rr_arb2 u_rd_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (rd_req),
    .en   (rd_en),
    .cand (rd_cand),
    .gnt  (rd_gnt)
  );

  assign wa     = wr_cand[1] ? wr_addr1 : wr_addr0;
  assign wd     = wr_cand[1] ? wr_data1 : wr_data0;
  assign ra     = rd_cand[1] ? rd_addr1 : rd_addr0;
  assign w_oor  = ({1'b0, wa} >= DEPTH_W);
  assign r_oor  = ({1'b0, ra} >= DEPTH_W);
  assign hazard = (|wr_gnt) && (|rd_cand) && (ra == wa);
  assign rd_en  = arb_en && !hazard;

  // ---------------- RAM ports ----------------
  always_comb begin
    if (clr_we) begin
      ram_we            = 1'b1;
      ram_write_address = cnt_q;
      ram_data          = '0;
    end else begin
      ram_we            = (|wr_gnt) && !w_oor;
      ram_write_address = wa;
      ram_data          = wd;
    end
    ram_read_address = ra;
  end

  // ---------------- read return / error ----------------
  always_comb begin
    rd_valid_d = rd_gnt;
    rd_oor_d   = (|rd_gnt) && r_oor;
    addr_err_d = ((|wr_gnt) && w_oor) || ((|rd_gnt) && r_oor);
  end

  // Out-of-range reads return zero instead of whatever the RAM drives.
  assign rd_valid = rd_valid_q;
  assign rd_data  = ((|rd_valid_q) && !rd_oor_q) ? ram_q : '0;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_texture_ram_arbiter.sv
module tb_texture_ram_arbiter;

  localparam int DEPTH = 300;
  localparam int AW    = 17;
  localparam int DW    = 32;

  logic          clk;
  logic          rst;
  logic [1:0]    wr_req;
  logic [AW-1:0] wr_addr0, wr_addr1;
  logic [DW-1:0] wr_data0, wr_data1;
  logic [1:0]    wr_gnt;
  logic [1:0]    rd_req;
  logic [AW-1:0] rd_addr0, rd_addr1;
  logic [1:0]    rd_gnt;
  logic [1:0]    rd_valid;
  logic [DW-1:0] rd_data;
  logic          ram_we;
  logic [AW-1:0] ram_write_address;
  logic [DW-1:0] ram_data;
  logic [AW-1:0] ram_read_address;
  logic [DW-1:0] ram_q;
  logic          clear_start;
  logic          busy;
  logic          clear_done;
  logic          addr_err;

  int checks;
  int errors;

  texture_ram_arbiter #(.TEX_DEPTH(DEPTH), .TEX_AW(AW), .TEX_DW(DW)) dut (
    .clk               (clk),
    .rst               (rst),
    .wr_req            (wr_req),
    .wr_addr0          (wr_addr0),
    .wr_addr1          (wr_addr1),
    .wr_data0          (wr_data0),
    .wr_data1          (wr_data1),
    .wr_gnt            (wr_gnt),
    .rd_req            (rd_req),
    .rd_addr0          (rd_addr0),
    .rd_addr1          (rd_addr1),
    .rd_gnt            (rd_gnt),
    .rd_valid          (rd_valid),
    .rd_data           (rd_data),
    .ram_we            (ram_we),
    .ram_write_address (ram_write_address),
    .ram_data          (ram_data),
    .ram_read_address  (ram_read_address),
    .ram_q             (ram_q),
    .clear_start       (clear_start),
    .busy              (busy),
    .clear_done        (clear_done),
    .addr_err          (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical RAM attached to the DUT's ports
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we && int'(ram_write_address) < DEPTH) mem[int'(ram_write_address)] <= ram_data;
    ram_q <= (int'(ram_read_address) < DEPTH) ? mem[int'(ram_read_address)] : 32'h0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Round-robin: lone requester wins; if both request, the favourite wins and
  // the other becomes favourite for next time.
  function automatic int pick(input logic [1:0] req, input int fav);
    if (req == 2'b11) return fav;
    if (req == 2'b01) return 0;
    if (req == 2'b10) return 1;
    return -1;
  endfunction

  function automatic logic [1:0] onehot(input int idx);
    if (idx == 0) return 2'b01;
    if (idx == 1) return 2'b10;
    return 2'b00;
  endfunction

  logic [DW-1:0] ref_mem [DEPTH];
  int            m_mode;     // 0 idle, 1 clearing, 2 done
  int            m_left;     // words still to clear
  int            w_fav, r_fav;
  logic [1:0]    e_rdv;
  logic [DW-1:0] e_rdd;
  logic          e_err;

  int            mw, mrc, mr;
  logic [AW-1:0] mwa, mra;
  logic [DW-1:0] mwd;
  bit            mwo, mro;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    m_mode = 0; m_left = 0; w_fav = 0; r_fav = 0;
    e_rdv = '0; e_rdd = '0; e_err = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_clear_done", clear_done, 0);
        chk("rst_addr_err", addr_err, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_gnt", {wr_gnt, rd_gnt}, 0);
        m_mode = 0; m_left = 0; w_fav = 0; r_fav = 0;
        e_rdv = '0; e_rdd = '0; e_err = 1'b0;
      end else begin
        chk("m_rd_valid", rd_valid, e_rdv);
        if (e_rdv != 2'b00) chk("m_rd_data", rd_data, e_rdd);
        chk("m_addr_err", addr_err, e_err);
        chk("m_busy", busy, m_mode == 1);
        chk("m_clear_done", clear_done, m_mode == 2);
        if (m_mode == 0) begin
          mw  = pick(wr_req, w_fav);
          mrc = pick(rd_req, r_fav);
          mwa = (mw == 1) ? wr_addr1 : wr_addr0;
          mwd = (mw == 1) ? wr_data1 : wr_data0;
          mra = (mrc == 1) ? rd_addr1 : rd_addr0;
          mr  = (mw >= 0 && mrc >= 0 && mra == mwa) ? -1 : mrc;
          mwo = (mw >= 0) && (int'(mwa) >= DEPTH);
          mro = (mr >= 0) && (int'(mra) >= DEPTH);
          chk("m_wr_gnt", wr_gnt, onehot(mw));
          chk("m_rd_gnt", rd_gnt, onehot(mr));
          chk("m_ram_we", ram_we, (mw >= 0) && !mwo);
          if (mr >= 0 && !mro) chk("m_ram_raddr", ram_read_address, mra);
          e_rdv = onehot(mr);
          e_rdd = (mr >= 0 && !mro) ? ref_mem[int'(mra)] : '0;
          e_err = mwo || mro;
          if (mw >= 0 && !mwo) begin
            chk("m_ram_waddr", ram_write_address, mwa);
            chk("m_ram_wdata", ram_data, mwd);
            ref_mem[int'(mwa)] = mwd;
          end
          if (wr_req == 2'b11 && mw >= 0) w_fav = 1 - mw;
          if (rd_req == 2'b11 && mr >= 0) r_fav = 1 - mr;
          if (clear_start) begin
            m_mode = 1;
            m_left = DEPTH;
          end
        end else if (m_mode == 1) begin
          chk("m_clr_gnt", {wr_gnt, rd_gnt}, 0);
          chk("m_clr_we", ram_we, 1);
          chk("m_clr_addr", ram_write_address, DEPTH - m_left);
          chk("m_clr_data", ram_data, 0);
          ref_mem[DEPTH - m_left] = '0;
          m_left--;
          if (m_left == 0) m_mode = 2;
          e_rdv = '0; e_err = 1'b0;
        end else begin
          chk("m_done_gnt", {wr_gnt, rd_gnt}, 0);
          chk("m_done_we", ram_we, 0);
          m_mode = 0;
          e_rdv = '0; e_err = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic quiet();
    wr_req = 2'b00; rd_req = 2'b00; clear_start = 1'b0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int s;
    s = $urandom_range(0, 15);
    if (s == 0) return AW'(DEPTH - 1);
    if (s == 1) return AW'(DEPTH);
    if (s == 2) return 17'h1FFFF;
    return AW'($urandom_range(0, 9));
  endfunction

  int busy_cnt, done_cnt, gnt_seen, waited;
  bit done_seen;

  initial begin
    rst = 1'b1;
    quiet();
    wr_addr0 = '0; wr_addr1 = '0; wr_data0 = '0; wr_data1 = '0;
    rd_addr0 = '0; rd_addr1 = '0;
    repeat (2) @(negedge clk);
    #3;
    chk("reset_busy", busy, 0);
    chk("reset_rd_valid", rd_valid, 0);
    @(negedge clk); rst = 1'b0;

    // write/read hazard on the same address
    @(negedge clk);
    wr_req = 2'b01; wr_addr0 = 17'd5; wr_data0 = 32'hDEADBEEF;
    rd_req = 2'b01; rd_addr0 = 17'd5;
    #3; chk("haz_wr_gnt", wr_gnt, 2'b01); chk("haz_rd_gnt", rd_gnt, 2'b00);
    @(negedge clk); wr_req = 2'b00;
    #3; chk("haz_retry_gnt", rd_gnt, 2'b01);
    @(negedge clk); rd_req = 2'b00;
    #3; chk("haz_rd_valid", rd_valid, 2'b01); chk("haz_rd_data", rd_data, 32'hDEADBEEF);

    // read fairness
    rd_addr0 = 17'd10; rd_addr1 = 17'd11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); rd_req = 2'b11;
      #3;
      chk("rd_fair_gnt", rd_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) chk("rd_fair_vld", rd_valid, (i % 2 == 0) ? 2'b10 : 2'b01);
    end
    @(negedge clk); rd_req = 2'b00;
    #3; chk("rd_fair_last_vld", rd_valid, 2'b10);

    // write fairness
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wr_req = 2'b11;
      wr_addr0 = AW'(20 + i); wr_data0 = 32'hA0000000 + i;
      wr_addr1 = AW'(40 + i); wr_data1 = 32'hB0000000 + i;
      #3; chk("wr_fair_gnt", wr_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    @(negedge clk); wr_req = 2'b00;
    #3;
    chk("wr_fair_mem20", mem[20], 32'hA0000000);
    chk("wr_fair_mem41", mem[41], 32'hB0000001);
    chk("wr_fair_mem22", mem[22], 32'hA0000002);
    chk("wr_fair_mem43", mem[43], 32'hB0000003);

    // out-of-range accesses
    @(negedge clk); wr_req = 2'b01; wr_addr0 = 17'd107120;
    #3; chk("oor_wr_gnt", wr_gnt, 2'b01); chk("oor_wr_we", ram_we, 0);
    @(negedge clk); wr_req = 2'b00; rd_req = 2'b10; rd_addr1 = 17'd131071;
    #3; chk("oor_wr_err", addr_err, 1); chk("oor_rd_gnt", rd_gnt, 2'b10);
    @(negedge clk); rd_req = 2'b00;
    #3; chk("oor_rd_vld", rd_valid, 2'b10); chk("oor_rd_data", rd_data, 0); chk("oor_rd_err", addr_err, 1);
    @(negedge clk); wr_req = 2'b01; wr_addr0 = AW'(DEPTH - 1); wr_data0 = 32'h55555555;
    #3; chk("edge_wr_we", ram_we, 1); chk("edge_no_err", addr_err, 0);

    // clear, with a read granted in the start cycle
    @(negedge clk); wr_req = 2'b01; wr_addr0 = 17'd0; wr_data0 = 32'h12345678;
    @(negedge clk); wr_req = 2'b00; clear_start = 1'b1; rd_req = 2'b01; rd_addr0 = 17'd0;
    #3; chk("clr_start_rd_gnt", rd_gnt, 2'b01);
    @(negedge clk); clear_start = 1'b0; rd_req = 2'b00;
    #3; chk("clr_pre_rd_vld", rd_valid, 2'b01); chk("clr_pre_rd_data", rd_data, 32'h12345678);
    busy_cnt = busy ? 1 : 0; done_cnt = 0; gnt_seen = 0; waited = 0; done_seen = 0;
    while (!done_seen && waited < 2 * DEPTH) begin
      @(negedge clk);
      wr_req = 2'($urandom); rd_req = 2'($urandom);
      wr_addr0 = rand_addr(); rd_addr0 = rand_addr();
      clear_start = (waited < 50);
      #3;
      if (busy) busy_cnt++;
      if (wr_gnt != 2'b00 || rd_gnt != 2'b00) gnt_seen++;
      if (clear_done) begin done_cnt++; done_seen = 1; end
      waited++;
    end
    if (!done_seen) chk("clr_timeout", 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); quiet();
      #3; if (clear_done) done_cnt++;
    end
    chk("clr_busy_cycles", busy_cnt, DEPTH);
    chk("clr_done_pulses", done_cnt, 1);
    chk("clr_no_grants", gnt_seen, 0);
    @(negedge clk); rd_req = 2'b01; rd_addr0 = 17'd0;
    @(negedge clk); rd_addr0 = AW'(DEPTH - 1);
    #3; chk("clr_mem0", rd_data, 0);
    @(negedge clk); rd_req = 2'b00;
    #3; chk("clr_mem_last", rd_data, 0);

    // reset in the middle of a clear
    @(negedge clk); clear_start = 1'b1;
    @(negedge clk); clear_start = 1'b0;
    repeat (99) @(negedge clk);
    rst = 1'b1;
    #3; chk("midrst_busy", busy, 0); chk("midrst_done", clear_done, 0);
    @(negedge clk); rst = 1'b0;
    done_cnt = 0;
    repeat (5) begin
      @(negedge clk); #3; if (clear_done || busy) done_cnt++;
    end
    chk("midrst_quiet", done_cnt, 0);
    @(negedge clk); wr_req = 2'b10; wr_addr1 = 17'd7; wr_data1 = 32'hCAFE0007;
    #3; chk("midrst_wr_gnt", wr_gnt, 2'b10);
    @(negedge clk); wr_req = 2'b00; rd_req = 2'b01; rd_addr0 = 17'd7;
    #3; chk("midrst_rd_gnt", rd_gnt, 2'b01);
    @(negedge clk); rd_req = 2'b00;
    #3; chk("midrst_rd_data", rd_data, 32'hCAFE0007);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      wr_req   = 2'($urandom);
      rd_req   = 2'($urandom);
      wr_addr0 = rand_addr(); wr_addr1 = rand_addr();
      rd_addr0 = rand_addr(); rd_addr1 = rand_addr();
      wr_data0 = $urandom;    wr_data1 = $urandom;
      clear_start = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk); quiet();
    @(negedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/texture_ram_arbiter.md
TEXTURE_RAM_ARBITER -- requirements
Module: texture_ram_arbiter

Interface
REQ-001 SHALL have parameters: TEX_DEPTH, 107120, number of texture words; TEX_AW, 17, address width; TEX_DW, 32, data width.
REQ-002 SHALL use one clock and an asynchronous, active-high reset.
REQ-003 clk  in  1  clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 wr_req  in  2  write request, one bit per writer (0 = texture loader, 1 = rasterizer).
REQ-006 wr_addr0, wr_addr1  in  TEX_AW  write address per writer.
REQ-007 wr_data0, wr_data1  in  TEX_DW  write data per writer.
REQ-008 wr_gnt  out  2  write grant; request consumed in a cycle where the bit is 1.
REQ-009 rd_req  in  2  read request, one bit per reader (0 = sampler, 1 = output controller).
REQ-010 rd_addr0, rd_addr1  in  TEX_AW  read address per reader.
REQ-011 rd_gnt  out  2  read grant; request consumed in a cycle where the bit is 1.
REQ-012 rd_valid  out  2  registered; bit i = 1 the cycle after rd_gnt[i].
REQ-013 rd_data  out  TEX_DW  read data, qualified by rd_valid.
REQ-014 ram_we, ram_write_address, ram_data  out  1/TEX_AW/TEX_DW  RAM write port.
REQ-015 ram_read_address  out  TEX_AW  RAM read port address.
REQ-016 ram_q  in  TEX_DW  RAM read data, valid one cycle after ram_read_address.
REQ-017 clear_start  in  1  pulse: zero the whole RAM.
REQ-018 busy  out  1  1 while a clear is in progress.
REQ-019 clear_done  out  1  one-cycle pulse when a clear completes.
REQ-020 addr_err  out  1  one-cycle pulse when any granted address is >= TEX_DEPTH.

Function
REQ-021 Grants SHALL be combinational from the current requests and state, with at most one write grant and at most one read grant per cycle.
REQ-022 Write and read arbitration SHALL each be independent two-way round-robin; the pointer passes to the other requester only after a grant while both requested.
REQ-023 ram_we SHALL equal OR(wr_gnt) when the granted address is in range; ram_write_address and ram_data SHALL come from the granted writer.
REQ-024 The granted reader's address SHALL drive ram_read_address; rd_data SHALL equal ram_q when rd_valid is nonzero, giving 1-cycle read latency from grant.
REQ-025 Hazard: if the read candidate's address equals a same-cycle granted write address, rd_gnt SHALL be 0 that cycle, the read pointer SHALL hold, and the read is retried the next cycle.
REQ-026 Out-of-range handling:
  - write at an address >= TEX_DEPTH: granted, ram_we = 0, addr_err pulses;
  - read at an address >= TEX_DEPTH: granted, rd_valid asserted next cycle with rd_data = 0, addr_err pulses.
REQ-027 FSM states SHALL be IDLE, CLEAR and DONE.
  - IDLE -> CLEAR on clear_start.
  - CLEAR: write 0 to counter address, one per cycle from 0 to TEX_DEPTH-1; at TEX_DEPTH-1, go to DONE.
  - DONE -> IDLE after one cycle.
REQ-028 In CLEAR and DONE, wr_gnt and rd_gnt SHALL be 0 and arbitration pointers SHALL hold; busy = 1 in CLEAR only; clear_done = 1 in DONE only.
REQ-029 clear_start outside IDLE SHALL be ignored; clear_start coinciding with requests in IDLE SHALL still grant them that cycle, and CLEAR begins next cycle.
REQ-030 A read granted in the cycle before CLEAR SHALL still return rd_valid and its data.

Reset
REQ-031 On rst, all registered state SHALL take its reset value immediately:
  - FSM = IDLE, clear counter = 0;
  - both arbitration pointers = requester 0;
  - rd_valid = 0, busy = 0, clear_done = 0, addr_err = 0, ram_we = 0.
REQ-032 Reset during CLEAR SHALL abort the clear with no clear_done pulse; RAM contents are then unspecified.

Structure
REQ-033 Package texture_ram_pkg SHALL hold TEX_DEPTH, TEX_AW, TEX_DW and the FSM state enum.
REQ-034 The two-way round-robin SHALL be sub-module rr_arb2, instanced once for writes and once for reads.

Verification
REQ-035 Write hazard: wr_req=01 (addr 5, data 0xDEADBEEF) and rd_req=01 (addr 5) in the same cycle -> wr_gnt=01, rd_gnt=00; next cycle rd_gnt=01; the cycle after, rd_valid=01 and rd_data=0xDEADBEEF.
REQ-036 Read fairness: both readers request continuously -> rd_gnt sequence 01,10,01,10; each rd_valid follows its grant by one cycle.
REQ-037 Write fairness: both writers request for 4 cycles -> wr_gnt alternates starting with 01; RAM holds the data of all four writes.
REQ-038 Address error: wr_addr0=107120 requested -> wr_gnt=01, ram_we=0, addr_err pulse; rd_addr1=131071 -> rd_valid=10 with rd_data=0 and an addr_err pulse.
REQ-039 Clear: preload addr 0 and 107119, pulse clear_start -> busy=1 for 107120 cycles, no grants, clear_done pulses once, then both addresses read 0.
REQ-040 Reset mid-clear: rst asserted 100 cycles into CLEAR -> busy=0 immediately, no clear_done, and normal grants resume after rst deasserts.
